// File: rtl/io_fifo_port_if.sv
// Bus-side strobes/address and device-side valid/ready streams of the I/O FIFO port.
// The bidirectional Data bus stays a plain top-level inout net.
interface io_fifo_port_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  CS;
  logic                  RD_N;
  logic                  WR_N;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport master (
    output CS, RD_N, WR_N, Address, tx_ready, rx_data, rx_valid,
    input  tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  CS, RD_N, WR_N, Address, tx_ready, rx_data, rx_valid,
    output tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/io_fifo_port.sv
// I/O-mapped 8088 FIFO peripheral: CPU OUT feeds a TX stream, a device RX stream is read with IN,
// plus a status register and a control register for flushes and sticky-flag clears.
module io_fifo_port #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  io_fifo_port_if.slave         bus,
  inout  wire  [DATA_WIDTH-1:0] Data
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    REG_DATA   = 2'b00,
    REG_STATUS = 2'b01,
    REG_CTRL   = 2'b10,
    REG_RSVD   = 2'b11
  } reg_sel_t;

  reg_sel_t sel;
  logic     unused_addr;

  logic                  rd_n_q, wr_n_q, rd_ok, wr_ok;
  logic [DATA_WIDTH-1:0] wr_byte;
  logic                  wr_commit, rd_commit;
  logic                  flush_tx, flush_rx, clr_sticky;

  logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
  logic [PW-1:0]         tx_wp, tx_rp, rx_wp, rx_rp;
  logic [PW:0]           tx_cnt, rx_cnt;
  logic                  tx_ovf, rx_ovf;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic                  tx_push, tx_pop, rx_push, rx_pop;
  logic                  tx_ovf_set, rx_ovf_set;
  logic [DATA_WIDTH-1:0] rd_val;

  assign sel         = reg_sel_t'(bus.Address[1:0]);
  assign unused_addr = ^bus.Address[ADDR_WIDTH-1:2];

  // rd_ok/wr_ok stay low until the strobe has been seen high after reset, so a strobe that
  // was already active when reset hit cannot produce a rising-edge commit afterwards.
  assign wr_commit = wr_ok & ~wr_n_q & bus.WR_N & bus.CS;
  assign rd_commit = rd_ok & ~rd_n_q & bus.RD_N & bus.CS;

  assign flush_tx   = wr_commit & (sel == REG_CTRL) & wr_byte[0];
  assign flush_rx   = wr_commit & (sel == REG_CTRL) & wr_byte[1];
  assign clr_sticky = wr_commit & (sel == REG_CTRL) & wr_byte[2];

  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);

  // A same-cycle pop frees the slot, so a full FIFO may still accept the push.
  assign tx_pop     = ~tx_empty & bus.tx_ready;
  assign tx_push    = wr_commit & (sel == REG_DATA) & (~tx_full | tx_pop);
  assign tx_ovf_set = wr_commit & (sel == REG_DATA) & tx_full & ~tx_pop;

  assign rx_pop     = rd_commit & (sel == REG_DATA) & ~rx_empty;
  assign rx_push    = bus.rx_valid & (~rx_full | rx_pop);
  assign rx_ovf_set = bus.rx_valid & rx_full & ~rx_pop;

  assign bus.tx_data  = tx_mem[tx_rp];
  assign bus.tx_valid = ~tx_empty;
  assign bus.rx_ready = ~rx_full;

  always_comb begin
    rd_val = '0;
    case (sel)
      REG_DATA:   if (!rx_empty) rd_val = rx_mem[rx_rp];
      REG_STATUS: rd_val[3:0] = {tx_ovf, rx_ovf, tx_full, ~rx_empty};
      default:    rd_val = '0;
    endcase
  end

  assign Data = (bus.CS & ~bus.RD_N & bus.WR_N) ? rd_val : 'z;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rd_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      rd_ok  <= 1'b0;
      wr_ok  <= 1'b0;
    end else begin
      rd_n_q <= bus.RD_N;
      wr_n_q <= bus.WR_N;
      rd_ok  <= rd_ok | bus.RD_N;
      wr_ok  <= wr_ok | bus.WR_N;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET)                      wr_byte <= '0;
    else if (bus.CS && !bus.WR_N)    wr_byte <= Data;
  end

  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wp] <= wr_byte;
    if (rx_push) rx_mem[rx_wp] <= bus.rx_data;
  end

  always_ff @(posedge CLK) begin
    if (!RESET || flush_tx) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET || flush_rx) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET || clr_sticky) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (tx_ovf_set) tx_ovf <= 1'b1;
      if (rx_ovf_set) rx_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_io_fifo_port.sv
// Scoreboard bench for io_fifo_port: queues model both FIFOs and sticky flags, bus cycles are
// driven as 8088-style strobes and every observation goes through one check task.
module tb_io_fifo_port;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic       drv_en = 1'b0;
  logic [7:0] drv_val = '0;
  wire  [7:0] Data;

  io_fifo_port_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus ();

  io_fifo_port #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .DEPTH(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus),
    .Data  (Data)
  );

  // Undriven bus floats high, so a released bus reads 8'hFF.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (Data[i]);
  end
  assign Data = drv_en ? drv_val : 'z;

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       tx_ovf_e = 1'b0;
  logic       rx_ovf_e = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] exp_status();
    return {4'h0, tx_ovf_e, rx_ovf_e, tx_q.size() == 8, rx_q.size() != 0};
  endfunction

  task automatic cpu_out(input logic [1:0] a, input logic [7:0] v);
    bus.CS = 1'b1; bus.Address = {14'h0, a}; bus.WR_N = 1'b0;
    drv_en = 1'b1; drv_val = v;
    tick();
    bus.WR_N = 1'b1; drv_en = 1'b0;
    tick();
    bus.CS = 1'b0;
    if (a == 2'd0) begin
      if (tx_q.size() < 8) tx_q.push_back(v);
      else                 tx_ovf_e = 1'b1;
    end else if (a == 2'd2) begin
      if (v[0]) tx_q.delete();
      if (v[1]) rx_q.delete();
      if (v[2]) begin tx_ovf_e = 1'b0; rx_ovf_e = 1'b0; end
    end
  endtask

  task automatic cpu_in(input string tag, input logic [1:0] a);
    logic [7:0] e;
    case (a)
      2'd0:    e = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
      2'd1:    e = exp_status();
      default: e = 8'h00;
    endcase
    bus.CS = 1'b1; bus.Address = {14'h0, a}; bus.RD_N = 1'b0;
    @(negedge CLK);
    check(tag, Data, e);
    tick();
    bus.RD_N = 1'b1;
    tick();
    bus.CS = 1'b0;
    if (a == 2'd0 && rx_q.size() != 0) void'(rx_q.pop_front());
  endtask

  task automatic dev_push(input logic [7:0] v);
    bus.rx_valid = 1'b1; bus.rx_data = v;
    tick();
    bus.rx_valid = 1'b0;
    if (rx_q.size() < 8) rx_q.push_back(v);
    else                 rx_ovf_e = 1'b1;
  endtask

  task automatic drain_one(input string tag);
    logic [7:0] e;
    e = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
    bus.tx_ready = 1'b1;
    @(negedge CLK);
    check({tag, "_valid"}, bus.tx_valid, 1);
    check({tag, "_data"}, bus.tx_data, e);
    tick();
    bus.tx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.CS = 1'b0; bus.RD_N = 1'b1; bus.WR_N = 1'b1; bus.Address = '0;
    bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;
    tick(); tick();
    @(negedge CLK);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_rx_ready", bus.rx_ready, 1);
    check("rst_data_z", Data, 8'hFF);
    tick();
    RESET = 1'b1;
    tick(); tick();
    cpu_in("rst_status", 2'd1);

    // single OUT, one-cycle latency, then device drains it
    cpu_out(2'd0, 8'hA5);
    check("t1_tx_valid", bus.tx_valid, 1);
    check("t1_tx_data", bus.tx_data, 8'hA5);
    drain_one("t1_drain");
    check("t1_tx_empty", bus.tx_valid, 0);

    // fill TX, overflow, drain, refill across pointer wrap
    for (int i = 1; i <= 8; i++) cpu_out(2'd0, 8'(i));
    cpu_in("t2_status_full", 2'd1);
    cpu_out(2'd0, 8'hFF);
    cpu_in("t2_status_ovf", 2'd1);
    for (int i = 0; i < 8; i++) drain_one("t2_drain");
    check("t2_tx_empty", bus.tx_valid, 0);
    for (int i = 0; i < 3; i++) cpu_out(2'd0, 8'(8'h20 + i));
    for (int i = 0; i < 3; i++) drain_one("t2_part");
    cpu_out(2'd2, 8'h04);
    for (int i = 0; i < 8; i++) cpu_out(2'd0, 8'(8'h40 + i));
    cpu_in("t2_status_wrap", 2'd1);
    for (int i = 0; i < 8; i++) drain_one("t2_wrap");

    // RX path, empty pop leaves pointers alone
    dev_push(8'h3C);
    cpu_in("t3_status_1", 2'd1);
    dev_push(8'hC3);
    cpu_in("t3_in_a", 2'd0);
    cpu_in("t3_in_b", 2'd0);
    cpu_in("t3_status_0", 2'd1);
    cpu_in("t3_in_empty", 2'd0);
    dev_push(8'h55);
    cpu_in("t3_in_after", 2'd0);
    cpu_in("t3_reserved", 2'd3);
    cpu_in("t3_ctrl_rd", 2'd2);

    // RX full, same-cycle push and pop, then overflow and clear
    for (int i = 0; i < 8; i++) dev_push(8'(8'h80 + i));
    @(negedge CLK);
    check("t4_rx_full", bus.rx_ready, 0);
    cpu_in("t4_status_full", 2'd1);
    bus.CS = 1'b1; bus.Address = '0; bus.RD_N = 1'b0;
    @(negedge CLK);
    check("t4_pop_data", Data, rx_q[0]);
    tick();
    bus.RD_N = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = 8'h99;
    tick();
    bus.rx_valid = 1'b0; bus.CS = 1'b0;
    void'(rx_q.pop_front());
    rx_q.push_back(8'h99);
    @(negedge CLK);
    check("t4_still_full", bus.rx_ready, 0);
    cpu_in("t4_no_ovf", 2'd1);
    dev_push(8'hAA);
    cpu_in("t4_ovf", 2'd1);
    cpu_out(2'd2, 8'h04);
    cpu_in("t4_ovf_clr", 2'd1);
    for (int i = 0; i < 8; i++) cpu_in("t4_drain", 2'd0);
    cpu_in("t4_status_end", 2'd1);

    // flush both FIFOs, bus release checks
    cpu_out(2'd0, 8'hA1); cpu_out(2'd0, 8'hA2); cpu_out(2'd0, 8'hA3);
    dev_push(8'hB1); dev_push(8'hB2);
    cpu_in("t5_status_pre", 2'd1);
    cpu_out(2'd2, 8'h03);
    check("t5_tx_flushed", bus.tx_valid, 0);
    check("t5_rx_ready", bus.rx_ready, 1);
    cpu_in("t5_status_post", 2'd1);
    bus.CS = 1'b0; bus.RD_N = 1'b0; bus.Address = 16'h0001;
    @(negedge CLK);
    check("t5_z_cs0", Data, 8'hFF);
    tick();
    bus.CS = 1'b1; bus.RD_N = 1'b1;
    @(negedge CLK);
    check("t5_z_rd1", Data, 8'hFF);
    tick();
    bus.RD_N = 1'b0; bus.WR_N = 1'b0;
    @(negedge CLK);
    check("t5_z_wr0", Data, 8'hFF);
    tick();
    bus.RD_N = 1'b1; bus.WR_N = 1'b1;
    tick();
    bus.CS = 1'b0;
    tick();

    // reset in the middle of an OUT
    cpu_out(2'd0, 8'h11);
    dev_push(8'h22);
    bus.CS = 1'b1; bus.Address = '0; bus.WR_N = 1'b0; drv_en = 1'b1; drv_val = 8'h77;
    tick();
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    bus.WR_N = 1'b1; drv_en = 1'b0;
    tick();
    bus.CS = 1'b0;
    tx_q.delete(); rx_q.delete(); tx_ovf_e = 1'b0; rx_ovf_e = 1'b0;
    tick();
    @(negedge CLK);
    check("t6_tx_valid", bus.tx_valid, 0);
    check("t6_rx_ready", bus.rx_ready, 1);
    check("t6_data_z", Data, 8'hFF);
    cpu_in("t6_status", 2'd1);
    cpu_out(2'd0, 8'h44);
    drain_one("t6_after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
